spi_slave_ctrl: RTL and testbench
=================================

Name: spi_slave_ctrl

Overview:
Parametrised SPI slave for the FPGA side of the MCU link. It supports configurable word width, all four SPI modes (selected at runtime), MSB- or LSB-first shifting, and input synchronisers. Transmit and receive paths use valid/ready handshakes instead of the bare done/din/dout pulse interface. The block sits between the external SPI pins and the command/packet logic in the clk domain.

Parameters:
WIDTH, 8, bits per SPI word (2..32)
SYNC_STAGES, 2, synchroniser flops on sck/ss/mosi (>=2)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first
FILL, {WIDTH{1'b1}}, word transmitted when no TX data is available

Ports:
clk  in  1  system clock, at least 4x sck
rst  in  1  synchronous reset, active-low
cpol  in  1  clock polarity, sampled only while ss is high
cpha  in  1  clock phase, sampled only while ss is high
ss  in  1  slave select, active-low
sck  in  1  SPI clock
mosi  in  1  master out slave in
miso  out  1  master in slave out
miso_oe  out  1  miso output enable (1 = drive)
tx_data  in  WIDTH  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX holding register empty
rx_data  out  WIDTH  last received word
rx_valid  out  1  rx_data valid, held until accepted
rx_ready  in  1  consumer accepts rx_data
done  out  1  one-cycle pulse per completed word
busy  out  1  ss asserted (synchronised)
tx_underrun  out  1  one-cycle pulse when FILL is loaded
rx_overrun  out  1  one-cycle pulse when a received word is dropped

Behaviour:
- Reset (rst=0 at posedge clk): miso=1, miso_oe=0, tx_ready=1, rx_valid=0, rx_data=0, done=0, busy=0, tx_underrun=0, rx_overrun=0, bit counter=0, mode regs=0, shift regs=FILL. Synchroniser flops are not reset.
- All pin inputs are synchronised through SYNC_STAGES flops. Edges are detected on the synchronised sck against its previous value. Pin-to-internal latency is SYNC_STAGES+1 cycles.
- Mode latch: while synchronised ss=1, cpol/cpha are copied every cycle. They are frozen while ss=0.
- Edge classification:
  - Leading edge = synchronised sck leaves the cpol level; trailing edge = returns to it.
  - cpha=0: sample on leading, shift out on trailing.
  - cpha=1: shift out on leading, sample on trailing.
- TX holding register:
  - tx_ready=1 while empty; the tx_valid&&tx_ready handshake fills it.
  - A load into the shift register empties it. A handshake in the same cycle as a load refills it (load takes the old content).
- Shift-register load occurs:
  - (a) every cycle while ss=1 and the holding register is full, and
  - (b) on the sample edge of the last bit.
  - If the holding register is empty at (b), or at the ss falling edge, FILL is loaded and tx_underrun pulses.
- miso timing:
  - While ss=1: miso presents the first bit of the shift register (MSB if MSB_FIRST), so cpha=0 has bit 0 valid before the first edge.
  - cpha=1: first bit is driven on the first leading edge.
- miso_oe = ~synchronised ss.
- Receive:
  - Each sample edge shifts in mosi and increments the bit counter (0..WIDTH-1, wraps).
  - On the sample edge where counter==WIDTH-1, the word completes: done=1 next cycle.
  - If rx_valid=0 or rx_ready=1 that cycle, rx_data is updated and rx_valid=1. Otherwise the new word is dropped, rx_data is kept, and rx_overrun pulses.
- rx_valid clears on rx_valid&&rx_ready unless a new word lands in the same cycle, in which case it stays 1 with new data.
- ss rising mid-word: bit counter resets to 0 and the partial RX word is discarded (no done). The TX shift register reloads per (a). The holding register is untouched.
- Back-to-back words without ss deassert are supported. The counter wraps and the next word starts immediately.
- Changing cpol/cpha while ss=0 has no effect until ss deasserts.

Decomposition:
- Package spi_pkg: SPI mode encodings (MODE0..MODE3 as {cpol,cpha}), default FILL constant, minimum SYNC_STAGES constant.
- Sub-module spi_sync_edge: N-stage synchroniser plus rise/fall detect, instantiated for sck, with plain sync for ss/mosi.
- Everything else stays in spi_slave_ctrl.

Test Plan:
- Mode 0, WIDTH=8, MSB first: preload tx 0xA5, master sends 0x3C. miso sequence reads 0xA5, rx_data=0x3C, rx_valid=1, one done pulse, tx_underrun=0.
- Modes 1/2/3 each: tx 0x81, rx 0x7E. Correct bytes both directions and cpol idle honoured; cpol toggled with ss low has no effect.
- No tx_valid, master sends 0x55: miso reads 0xFF and tx_underrun pulses once. Back-to-back 3 words with rx_ready=0: first word kept, two rx_overrun pulses.
- ss deasserted after 5 bits, then full word 0xC3: no done for the partial word, rx_data=0xC3, bit counter restarted.
- WIDTH=16, MSB_FIRST=0: tx 0x1234 appears LSB first on miso, rx 0xBEEF captured correctly.
- rst low mid-word: all outputs return to reset values the next cycle; the following full word transfers correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants for the SPI slave controller
package spi_pkg;

   // SPI modes encoded as {cpol, cpha}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   localparam logic [31:0] DEFAULT_FILL    = 32'hFFFF_FFFF;
   localparam int          MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - pin synchroniser with rise/fall detect on one input
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int STAGES = 2,
   parameter int W      = 2
) (
   input  logic         clk,
   input  logic         d_edge,
   input  logic [W-1:0] d_plain,
   output logic [W-1:0] q_plain,
   output logic         rise,
   output logic         fall
);

   localparam int N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

   logic [W:0] sync_q [N];
   logic       edge_prev;

   // No reset: these flops only ever carry the pin levels.
   always_ff @(posedge clk) begin
      sync_q[0] <= {d_plain, d_edge};
      for (int i = 1; i < N; i++) begin
         sync_q[i] <= sync_q[i-1];
      end
      edge_prev <= sync_q[N-1][0];
   end

   assign q_plain = sync_q[N-1][W:1];
   assign rise    = sync_q[N-1][0] & ~edge_prev;
   assign fall    = ~sync_q[N-1][0] & edge_prev;

endmodule

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI slave with runtime mode select and valid/ready TX/RX
module spi_slave_ctrl
   import spi_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter bit               MSB_FIRST   = 1'b1,
   parameter logic [WIDTH-1:0] FILL        = DEFAULT_FILL[WIDTH-1:0]
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpol,
   input  logic             cpha,
   input  logic             ss,
   input  logic             sck,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             done,
   output logic             busy,
   output logic             tx_underrun,
   output logic             rx_overrun
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic             sck_rise, sck_fall, ss_s, mosi_s;
   logic             cpol_r, cpha_r;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] rx_sh, rx_word, tx_sh, tx_sh_nxt, hold_data;
   logic             hold_full, fresh, fresh_nxt, load_hold, underrun_nxt;
   logic             lead, trail, sample_on_lead, sample, shift_en, word_done, ss_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .W(2)) u_sync (
      .clk     (clk),
      .d_edge  (sck),
      .d_plain ({mosi, ss}),
      .q_plain ({mosi_s, ss_s}),
      .rise    (sck_rise),
      .fall    (sck_fall)
   );

   assign lead           = cpol_r ? sck_fall : sck_rise;
   assign trail          = cpol_r ? sck_rise : sck_fall;
   assign sample_on_lead = ({cpol_r, cpha_r} == MODE0) || ({cpol_r, cpha_r} == MODE2);
   assign sample         = ~ss_s & (sample_on_lead ? lead : trail);
   // bit_cnt==0 on a shift edge means the word boundary: the freshly loaded bit 0 must stay
   assign shift_en       = ~ss_s & (sample_on_lead ? trail : lead) & (bit_cnt != '0);
   assign word_done      = sample & (bit_cnt == LAST);
   assign ss_fall        = ~ss_s & ~busy;
   assign rx_word        = MSB_FIRST ? {rx_sh[WIDTH-2:0], mosi_s} : {mosi_s, rx_sh[WIDTH-1:1]};
   assign tx_ready       = ~hold_full;
   assign miso_oe        = busy;

   // fresh marks a shift register holding unsent holding-register data, so a
   // word preloaded while ss was high is not replaced by FILL when ss falls.
   always_comb begin
      tx_sh_nxt    = tx_sh;
      fresh_nxt    = fresh;
      load_hold    = 1'b0;
      underrun_nxt = 1'b0;
      if (ss_s || word_done || ss_fall) begin
         if (hold_full) begin
            tx_sh_nxt = hold_data;
            fresh_nxt = 1'b1;
            load_hold = 1'b1;
         end else if (!ss_s && (word_done || !fresh)) begin
            tx_sh_nxt    = FILL;
            fresh_nxt    = 1'b0;
            underrun_nxt = 1'b1;
         end
      end else if (shift_en) begin
         tx_sh_nxt = MSB_FIRST ? {tx_sh[WIDTH-2:0], 1'b1} : {1'b1, tx_sh[WIDTH-1:1]};
         fresh_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         miso        <= 1'b1;
         busy        <= 1'b0;
         hold_full   <= 1'b0;
         hold_data   <= '0;
         tx_sh       <= FILL;
         rx_sh       <= FILL;
         fresh       <= 1'b0;
         bit_cnt     <= '0;
         cpol_r      <= 1'b0;
         cpha_r      <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         done        <= 1'b0;
         tx_underrun <= 1'b0;
         rx_overrun  <= 1'b0;
      end else begin
         busy        <= ~ss_s;
         tx_sh       <= tx_sh_nxt;
         fresh       <= fresh_nxt;
         miso        <= MSB_FIRST ? tx_sh_nxt[WIDTH-1] : tx_sh_nxt[0];
         tx_underrun <= underrun_nxt;
         done        <= 1'b0;
         rx_overrun  <= 1'b0;

         if (tx_valid && !hold_full) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
         end else if (load_hold) begin
            hold_full <= 1'b0;
         end

         if (ss_s) begin
            cpol_r  <= cpol;
            cpha_r  <= cpha;
            bit_cnt <= '0;
         end else if (sample) begin
            rx_sh   <= rx_word;
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
         end

         if (word_done) begin
            done <= 1'b1;
            if (!rx_valid || rx_ready) begin
               rx_data  <= rx_word;
               rx_valid <= 1'b1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - scoreboard bench for spi_slave_ctrl (8-bit MSB-first and 16-bit LSB-first)
`timescale 1ns/1ps
module tb_spi_slave_ctrl;

   localparam int HALF = 8;

   logic        clk, rst, cpol, cpha, sck, mosi, ss8, ss16;
   logic        miso8, oe8, txr8, rxv8, done8, busy8, und8, ovr8, txv8, rxr8;
   logic [7:0]  txd8, rxd8;
   logic        miso16, oe16, txr16, rxv16, done16, busy16, und16, ovr16, txv16, rxr16;
   logic [15:0] txd16, rxd16;

   typedef struct packed {
      logic [15:0] data;
      logic        ovr;
      logic        und;
   } exp_t;

   exp_t        q8[$], q16[$];
   exp_t        e8, e16, e_b;
   int          n_pass, n_chk, ufall8;
   logic [15:0] mi_b;

   spi_slave_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .ss(ss8), .sck(sck), .mosi(mosi),
      .miso(miso8), .miso_oe(oe8), .tx_data(txd8), .tx_valid(txv8), .tx_ready(txr8),
      .rx_data(rxd8), .rx_valid(rxv8), .rx_ready(rxr8), .done(done8), .busy(busy8),
      .tx_underrun(und8), .rx_overrun(ovr8)
   );

   spi_slave_ctrl #(.WIDTH(16), .MSB_FIRST(1'b0)) dut16 (
      .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .ss(ss16), .sck(sck), .mosi(mosi),
      .miso(miso16), .miso_oe(oe16), .tx_data(txd16), .tx_valid(txv16), .tx_ready(txr16),
      .rx_data(rxd16), .rx_valid(rxv16), .rx_ready(rxr16), .done(done16), .busy(busy16),
      .tx_underrun(und16), .rx_overrun(ovr16)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, got, exp);
   endtask

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Monitor: every done pulse pops the expected word and end-of-word flags
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (done8) begin
            if (q8.size() == 0) chk("unexpected_done8", q8.size(), 1);
            else begin
               e8 = q8.pop_front();
               chk("rx_data8", rxd8, e8.data);
               chk("rx_valid8", rxv8, 1);
               chk("rx_overrun8", ovr8, e8.ovr);
               chk("tx_underrun_end8", und8, e8.und);
            end
         end else begin
            if (und8) ufall8++;
            if (ovr8) chk("stray_overrun8", ovr8, 0);
         end
         if (done16) begin
            if (q16.size() == 0) chk("unexpected_done16", q16.size(), 1);
            else begin
               e16 = q16.pop_front();
               chk("rx_data16", rxd16, e16.data);
               chk("rx_overrun16", ovr16, e16.ovr);
               chk("tx_underrun_end16", und16, e16.und);
            end
         end
      end
   end

   task automatic spi_word(input logic [15:0] mo, input int nb, input logic lsb,
                           input logic c_pol, input logic c_pha, input logic sel16,
                           output logic [15:0] mi);
      mi = '0;
      for (int i = 0; i < nb; i++) begin
         int b;
         b = lsb ? i : nb - 1 - i;
         if (!c_pha) begin
            mosi = mo[b];
            wclk(HALF);
            mi[b] = sel16 ? miso16 : miso8;
            sck = ~c_pol;
            wclk(HALF);
            sck = c_pol;
         end else begin
            sck = ~c_pol;
            mosi = mo[b];
            wclk(HALF);
            mi[b] = sel16 ? miso16 : miso8;
            sck = c_pol;
            wclk(HALF);
         end
      end
   endtask

   task automatic xfer8(input logic [1:0] mode, input logic use_tx, input logic [7:0] txw,
                        input logic [7:0] mo, input logic [7:0] exp_miso, input int exp_ufall,
                        input logic tog, input string tag);
      logic [15:0] mi;
      exp_t        e;
      cpol = mode[1];
      cpha = mode[0];
      sck  = mode[1];
      wclk(HALF);
      if (use_tx) begin
         txd8 = txw;
         txv8 = 1'b1;
         wclk(1);
         txv8 = 1'b0;
         wclk(4);
      end
      ufall8 = 0;
      e.data = {8'h00, mo};
      e.ovr  = 1'b0;
      e.und  = 1'b1;
      q8.push_back(e);
      ss8 = 1'b0;
      wclk(HALF);
      chk({tag, "_busy"}, busy8, 1);
      chk({tag, "_miso_oe"}, oe8, 1);
      if (tog) cpol = ~cpol;
      spi_word({8'h00, mo}, 8, 1'b0, mode[1], mode[0], 1'b0, mi);
      wclk(HALF);
      ss8 = 1'b1;
      wclk(HALF);
      chk({tag, "_miso"}, mi, {8'h00, exp_miso});
      chk({tag, "_ufall"}, ufall8, exp_ufall);
      chk({tag, "_pending"}, q8.size(), 0);
      chk({tag, "_rx_data"}, rxd8, mo);
      rxr8 = 1'b1;
      wclk(1);
      rxr8 = 1'b0;
      chk({tag, "_rx_valid_clr"}, rxv8, 0);
   endtask

   task automatic chk_reset8(input string tag);
      chk({tag, "_miso"}, miso8, 1);
      chk({tag, "_miso_oe"}, oe8, 0);
      chk({tag, "_tx_ready"}, txr8, 1);
      chk({tag, "_rx_valid"}, rxv8, 0);
      chk({tag, "_rx_data"}, rxd8, 0);
      chk({tag, "_done"}, done8, 0);
      chk({tag, "_busy"}, busy8, 0);
      chk({tag, "_underrun"}, und8, 0);
      chk({tag, "_overrun"}, ovr8, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the end, got timeout, required completion");
      $fatal(1);
   end

   initial begin
      clk = 0; rst = 0; cpol = 0; cpha = 0; sck = 0; mosi = 1; ss8 = 1; ss16 = 1;
      txd8 = '0; txv8 = 0; rxr8 = 0; txd16 = '0; txv16 = 0; rxr16 = 0;
      n_pass = 0; n_chk = 0; ufall8 = 0;

      wclk(5);
      chk_reset8("reset");
      chk("reset_rx_data16", rxd16, 0);
      chk("reset_tx_ready16", txr16, 1);
      rst = 1;
      wclk(HALF);

      xfer8(2'b00, 1'b1, 8'hA5, 8'h3C, 8'hA5, 0, 1'b0, "mode0");
      xfer8(2'b01, 1'b1, 8'h81, 8'h7E, 8'h81, 0, 1'b0, "mode1");
      xfer8(2'b10, 1'b1, 8'h81, 8'h7E, 8'h81, 0, 1'b0, "mode2");
      xfer8(2'b11, 1'b1, 8'h81, 8'h7E, 8'h81, 0, 1'b1, "mode3_cpol_toggle");
      xfer8(2'b00, 1'b0, 8'h00, 8'h55, 8'hFF, 1, 1'b0, "underrun");

      // Three words in one frame, consumer stalled
      cpol = 0; cpha = 0; sck = 0;
      wclk(HALF);
      ufall8 = 0;
      e_b = '{data: 16'h0011, ovr: 1'b0, und: 1'b1}; q8.push_back(e_b);
      e_b = '{data: 16'h0011, ovr: 1'b1, und: 1'b1}; q8.push_back(e_b);
      e_b = '{data: 16'h0011, ovr: 1'b1, und: 1'b1}; q8.push_back(e_b);
      ss8 = 0;
      wclk(HALF);
      spi_word(16'h0011, 8, 1'b0, 1'b0, 1'b0, 1'b0, mi_b);
      chk("b2b_miso_first", mi_b, 16'h00FF);
      spi_word(16'h0022, 8, 1'b0, 1'b0, 1'b0, 1'b0, mi_b);
      spi_word(16'h0033, 8, 1'b0, 1'b0, 1'b0, 1'b0, mi_b);
      wclk(HALF);
      ss8 = 1;
      wclk(HALF);
      chk("b2b_pending", q8.size(), 0);
      chk("b2b_ufall", ufall8, 1);
      chk("b2b_rx_kept", rxd8, 8'h11);
      chk("b2b_rx_valid", rxv8, 1);
      rxr8 = 1;
      wclk(1);
      rxr8 = 0;

      // Partial word aborted by ss, then a full word
      ss8 = 0;
      wclk(HALF);
      spi_word(16'h001F, 5, 1'b0, 1'b0, 1'b0, 1'b0, mi_b);
      wclk(HALF);
      ss8 = 1;
      wclk(HALF);
      chk("partial_no_done", q8.size(), 0);
      xfer8(2'b00, 1'b1, 8'h5A, 8'hC3, 8'h5A, 0, 1'b0, "after_partial");

      // 16-bit LSB-first instance
      sck = 0;
      txd16 = 16'h1234;
      txv16 = 1;
      wclk(1);
      txv16 = 0;
      wclk(4);
      e_b = '{data: 16'hBEEF, ovr: 1'b0, und: 1'b1};
      q16.push_back(e_b);
      ss16 = 0;
      wclk(HALF);
      spi_word(16'hBEEF, 16, 1'b1, 1'b0, 1'b0, 1'b1, mi_b);
      wclk(HALF);
      ss16 = 1;
      wclk(HALF);
      chk("w16_miso", mi_b, 16'h1234);
      chk("w16_pending", q16.size(), 0);
      chk("w16_rx_data", rxd16, 16'hBEEF);
      chk("w16_rx_valid", rxv16, 1);

      // Reset in the middle of a word, with a pending TX word
      ss8 = 0;
      wclk(HALF);
      txd8 = 8'h77;
      txv8 = 1;
      wclk(1);
      txv8 = 0;
      spi_word(16'h0007, 3, 1'b0, 1'b0, 1'b0, 1'b0, mi_b);
      chk("midword_tx_ready", txr8, 0);
      rst = 0;
      wclk(1);
      chk_reset8("midword_reset");
      rst = 1;
      ss8 = 1;
      wclk(2 * HALF);
      xfer8(2'b00, 1'b1, 8'h96, 8'h69, 8'h96, 0, 1'b0, "after_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
